// File: rtl/park_pkg.sv
// Shared types and helpers for the car-park entry side: FSM encoding, slot math,
// and the token encrypt that exit_park's decrypt stage inverts.
package park_pkg;

    localparam int          SLOTS     = 8;
    localparam logic [2:0]  LFSR_SEED = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALLOC = 2'd1,
        ISSUE = 2'd2
    } entry_state_e;

    // Must remain the exact inverse of exit_park's decrypt (XOR is self-inverse).
    function automatic logic [2:0] encrypt(input logic [2:0] slot, input logic [2:0] pat);
        return slot ^ pat;
    endfunction

    function automatic logic [3:0] count_free(input logic [7:0] occ);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (!occ[i]) cnt = cnt + 4'd1;
        end
        return cnt;
    endfunction

    // Scans downward so the last hit is the lowest free index.
    function automatic logic [2:0] lowest_free(input logic [7:0] occ);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!occ[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/park_entry_manager_if.sv
// Driver-facing bus of the entry manager: entry/exit requests in, token and
// occupancy status out.
interface park_entry_manager_if;
    logic       enter;
    logic       exit;
    logic [7:0] exit_location;
    logic [2:0] token;
    logic [2:0] pattern;
    logic       token_valid;
    logic       reject;
    logic       exit_err;
    logic [7:0] occupancy;
    logic [3:0] free_count;
    logic       full;

    modport master (
        output enter, exit, exit_location,
        input  token, pattern, token_valid, reject, exit_err,
        input  occupancy, free_count, full
    );

    modport slave (
        input  enter, exit, exit_location,
        output token, pattern, token_valid, reject, exit_err,
        output occupancy, free_count, full
    );
endinterface

// File: rtl/pattern_lfsr.sv
// Free-running 3-bit Fibonacci LFSR (period 7) supplying token patterns.
module pattern_lfsr #(
    parameter logic [2:0] SEED = 3'b001
) (
    input  logic       clk,
    input  logic       reset,
    output logic [2:0] q
);
    logic [2:0] q_q, q_d;

    always_comb begin
        q_d = {q_q[1:0], q_q[2] ^ q_q[1]};
    end

    always_ff @(posedge clk) begin
        if (reset) q_q <= SEED;
        else       q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/park_entry_manager.sv
// Entry controller and occupancy-map owner: allocates the lowest free slot,
// issues slot^pattern tokens, and clears slots vacated through exit_park.
module park_entry_manager
    import park_pkg::*;
#(
    parameter logic [2:0] LFSR_SEED = park_pkg::LFSR_SEED,
    parameter int         SLOTS     = park_pkg::SLOTS
) (
    input  logic                 clk,
    input  logic                 reset,
    park_entry_manager_if.slave  bus
);
    entry_state_e     state_q, state_d;
    logic [2:0]       slot_q, slot_d;
    logic [2:0]       pat_reg_q, pat_reg_d;
    logic [2:0]       token_q, token_d;
    logic [2:0]       pattern_q, pattern_d;
    logic             token_valid_q, token_valid_d;
    logic             reject_q, reject_d;
    logic             exit_err_q, exit_err_d;
    logic [SLOTS-1:0] occ_q, occ_d;
    logic [3:0]       free_count_q, free_count_d;
    logic             full_q, full_d;
    logic [SLOTS-1:0] set_mask, clr_mask;
    logic [2:0]       lfsr;

    pattern_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        pat_reg_d     = pat_reg_q;
        token_d       = token_q;
        pattern_d     = pattern_q;
        token_valid_d = 1'b0;
        reject_d      = 1'b0;
        exit_err_d    = 1'b0;
        set_mask      = '0;
        clr_mask      = '0;

        // Exits are independent of the FSM; only a clean one-hot hit on an occupied slot clears.
        if (bus.exit) begin
            if (is_onehot(bus.exit_location) && ((bus.exit_location & occ_q) != '0))
                clr_mask = bus.exit_location;
            else
                exit_err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.enter) begin
                    if (full_q) reject_d = 1'b1;
                    else        state_d  = ALLOC;
                end
            end
            ALLOC: begin
                // Chosen from pre-clear occupancy so a concurrent exit cannot move it.
                slot_d    = lowest_free(occ_q);
                pat_reg_d = lfsr;
                state_d   = ISSUE;
            end
            ISSUE: begin
                set_mask      = SLOTS'(1) << slot_q;
                token_d       = encrypt(slot_q, pat_reg_q);
                pattern_d     = pat_reg_q;
                token_valid_d = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        occ_d        = (occ_q & ~clr_mask) | set_mask;
        free_count_d = count_free(occ_d);
        full_d       = &occ_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            slot_q        <= 3'd0;
            pat_reg_q     <= 3'd0;
            token_q       <= 3'd0;
            pattern_q     <= 3'd0;
            token_valid_q <= 1'b0;
            reject_q      <= 1'b0;
            exit_err_q    <= 1'b0;
            occ_q         <= '0;
            free_count_q  <= 4'(SLOTS);
            full_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            pat_reg_q     <= pat_reg_d;
            token_q       <= token_d;
            pattern_q     <= pattern_d;
            token_valid_q <= token_valid_d;
            reject_q      <= reject_d;
            exit_err_q    <= exit_err_d;
            occ_q         <= occ_d;
            free_count_q  <= free_count_d;
            full_q        <= full_d;
        end
    end

    assign bus.token       = token_q;
    assign bus.pattern     = pattern_q;
    assign bus.token_valid = token_valid_q;
    assign bus.reject      = reject_q;
    assign bus.exit_err    = exit_err_q;
    assign bus.occupancy   = occ_q;
    assign bus.free_count  = free_count_q;
    assign bus.full        = full_q;
endmodule
